// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use, branch redirect,
// data-memory wait and the multi-cycle mul/div handshake with timeout.
module pipeline_hazard_ctrl #(
    parameter int unsigned REGISTER_ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH           = 16,
    parameter int unsigned MD_TIMEOUT          = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [6:0]                     opcode_ID,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rs1_ID,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rs2_ID,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rd_EX,
    input  logic                           mem_read_EX,
    input  logic                           branch_taken_EX,
    input  logic                           md_EX,
    input  logic                           md_done,
    input  logic                           dmem_stall,
    output logic                           stall_PC,
    output logic                           stall_IF_ID,
    output logic                           stall_ID_EX,
    output logic                           stall_EX_MEM,
    output logic                           flush_IF_ID,
    output logic                           flush_ID_EX,
    output logic                           flush_EX_MEM,
    output logic                           md_start,
    output logic                           md_abort,
    output logic                           md_error,
    output logic [CNT_WIDTH-1:0]           stall_cycles,
    output logic [CNT_WIDTH-1:0]           flush_count
);

    localparam int unsigned WAIT_W = $clog2(MD_TIMEOUT);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_CAL_R  = 7'b0110011;

    typedef enum logic [0:0] {RUN, MD_WAIT} state_t;

    state_t              state, state_nxt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                wait_clr, wait_inc, err_set, br_flush;
    logic                use_rs1, use_rs2, load_use, md_timeout;

    // Operand-use decode and load-use detection on the ID instruction
    always_comb begin
        use_rs1  = !((opcode_ID == OP_LUI) || (opcode_ID == OP_AUIPC) || (opcode_ID == OP_JAL));
        use_rs2  = (opcode_ID == OP_BRANCH) || (opcode_ID == OP_STORE) || (opcode_ID == OP_CAL_R);
        load_use = mem_read_EX && (rd_EX != '0) &&
                   ((use_rs1 && (rs1_ID == rd_EX)) || (use_rs2 && (rs2_ID == rd_EX)));
    end

    assign md_timeout = (wait_cnt == WAIT_W'(MD_TIMEOUT - 1));

    // Next state and per-stage controls
    always_comb begin
        state_nxt    = state;
        stall_PC     = 1'b0;
        stall_IF_ID  = 1'b0;
        stall_ID_EX  = 1'b0;
        stall_EX_MEM = 1'b0;
        flush_IF_ID  = 1'b0;
        flush_ID_EX  = 1'b0;
        flush_EX_MEM = 1'b0;
        md_start     = 1'b0;
        md_abort     = 1'b0;
        wait_clr     = 1'b0;
        wait_inc     = 1'b0;
        err_set      = 1'b0;
        br_flush     = 1'b0;
        case (state)
            RUN: begin
                if (dmem_stall) begin
                    stall_PC     = 1'b1;
                    stall_IF_ID  = 1'b1;
                    stall_ID_EX  = 1'b1;
                    stall_EX_MEM = 1'b1;
                end else if (md_EX) begin
                    md_start     = 1'b1;
                    stall_PC     = 1'b1;
                    stall_IF_ID  = 1'b1;
                    stall_ID_EX  = 1'b1;
                    flush_EX_MEM = 1'b1;
                    wait_clr     = 1'b1;
                    state_nxt    = MD_WAIT;
                end else if (branch_taken_EX) begin
                    // The ID instruction dies on redirect, so load-use is moot
                    flush_IF_ID  = 1'b1;
                    flush_ID_EX  = 1'b1;
                    br_flush     = 1'b1;
                end else if (load_use) begin
                    stall_PC     = 1'b1;
                    stall_IF_ID  = 1'b1;
                    flush_ID_EX  = 1'b1;
                end
            end
            MD_WAIT: begin
                if (md_done || md_timeout) begin
                    // Release: done wins over a coincident timeout
                    state_nxt = RUN;
                    if (!md_done) begin
                        md_abort = 1'b1;
                        err_set  = 1'b1;
                    end
                    if (dmem_stall) begin
                        stall_PC     = 1'b1;
                        stall_IF_ID  = 1'b1;
                        stall_ID_EX  = 1'b1;
                        stall_EX_MEM = 1'b1;
                    end
                end else begin
                    wait_inc    = 1'b1;
                    stall_PC    = 1'b1;
                    stall_IF_ID = 1'b1;
                    stall_ID_EX = 1'b1;
                    if (dmem_stall) begin
                        stall_EX_MEM = 1'b1;
                    end else begin
                        flush_EX_MEM = 1'b1;
                    end
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            md_error <= 1'b0;
        end else begin
            state <= state_nxt;
            if (wait_clr) begin
                wait_cnt <= '0;
            end else if (wait_inc) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (err_set) begin
                md_error <= 1'b1;
            end
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_PC && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_WIDTH'(1);
            end
            if (br_flush && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (timeout 64 and 4) share stimulus
// and are compared every cycle against a cycle-count based behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned AW  = 5;
    localparam int unsigned CW  = 16;
    localparam int          SAT = (1 << CW) - 1;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_CAL_I  = 7'b0010011;
    localparam logic [6:0] OP_CAL_R  = 7'b0110011;

    typedef struct packed {
        logic spc, sif, sid, sem, fif, fid, fem, start, abort;
    } ctl_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    opcode_ID;
    logic [AW-1:0] rs1_ID, rs2_ID, rd_EX;
    logic          mem_read_EX, branch_taken_EX, md_EX, md_done, dmem_stall;

    logic [1:0]    o_spc, o_sif, o_sid, o_sem, o_fif, o_fid, o_fem, o_start, o_abort, o_err;
    logic [CW-1:0] o_sc [2];
    logic [CW-1:0] o_fc [2];

    int n_err = 0;
    int n_chk = 0;

    // Model state: per instance, in MD wait, cycles waited, sticky error, counters
    int tmo      [2] = '{64, 4};
    bit m_wait   [2] = '{0, 0};
    int m_waited [2] = '{0, 0};
    bit m_err    [2] = '{0, 0};
    int m_stalls [2] = '{0, 0};
    int m_flush  [2] = '{0, 0};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REGISTER_ADDR_WIDTH(AW), .CNT_WIDTH(CW), .MD_TIMEOUT(64)) dut0 (
        .clk(clk), .rst(rst), .opcode_ID(opcode_ID), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rd_EX(rd_EX), .mem_read_EX(mem_read_EX), .branch_taken_EX(branch_taken_EX),
        .md_EX(md_EX), .md_done(md_done), .dmem_stall(dmem_stall),
        .stall_PC(o_spc[0]), .stall_IF_ID(o_sif[0]), .stall_ID_EX(o_sid[0]),
        .stall_EX_MEM(o_sem[0]), .flush_IF_ID(o_fif[0]), .flush_ID_EX(o_fid[0]),
        .flush_EX_MEM(o_fem[0]), .md_start(o_start[0]), .md_abort(o_abort[0]),
        .md_error(o_err[0]), .stall_cycles(o_sc[0]), .flush_count(o_fc[0]));

    pipeline_hazard_ctrl #(.REGISTER_ADDR_WIDTH(AW), .CNT_WIDTH(CW), .MD_TIMEOUT(4)) dut1 (
        .clk(clk), .rst(rst), .opcode_ID(opcode_ID), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rd_EX(rd_EX), .mem_read_EX(mem_read_EX), .branch_taken_EX(branch_taken_EX),
        .md_EX(md_EX), .md_done(md_done), .dmem_stall(dmem_stall),
        .stall_PC(o_spc[1]), .stall_IF_ID(o_sif[1]), .stall_ID_EX(o_sid[1]),
        .stall_EX_MEM(o_sem[1]), .flush_IF_ID(o_fif[1]), .flush_ID_EX(o_fid[1]),
        .flush_EX_MEM(o_fem[1]), .md_start(o_start[1]), .md_abort(o_abort[1]),
        .md_error(o_err[1]), .stall_cycles(o_sc[1]), .flush_count(o_fc[1]));

    task automatic chk(input string name, input int k, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", name, k, $time, act, req);
        end
    endtask

    task automatic model_reset(input int k);
        m_wait[k]   = 0;
        m_waited[k] = 0;
        m_err[k]    = 0;
        m_stalls[k] = 0;
        m_flush[k]  = 0;
    endtask

    // Expected controls for this cycle, then advance the model by one clock
    task automatic model_step(input int k, output ctl_t e);
        bit u1, u2, lu, tout;
        e  = '0;
        u1 = !(opcode_ID inside {OP_LUI, OP_AUIPC, OP_JAL});
        u2 = opcode_ID inside {OP_BRANCH, OP_STORE, OP_CAL_R};
        lu = mem_read_EX && (rd_EX != 0) &&
             ((u1 && rs1_ID == rd_EX) || (u2 && rs2_ID == rd_EX));
        if (!m_wait[k]) begin
            if (dmem_stall) begin
                e.spc = 1; e.sif = 1; e.sid = 1; e.sem = 1;
            end else if (md_EX) begin
                e.start = 1; e.spc = 1; e.sif = 1; e.sid = 1; e.fem = 1;
                m_wait[k] = 1; m_waited[k] = 0;
            end else if (branch_taken_EX) begin
                e.fif = 1; e.fid = 1;
                if (m_flush[k] < SAT) m_flush[k]++;
            end else if (lu) begin
                e.spc = 1; e.sif = 1; e.fid = 1;
            end
        end else begin
            tout = !md_done && (m_waited[k] + 1 == tmo[k]);
            if (md_done || tout) begin
                e.abort = tout;
                if (dmem_stall) begin
                    e.spc = 1; e.sif = 1; e.sid = 1; e.sem = 1;
                end
                if (tout) m_err[k] = 1;
                m_wait[k] = 0;
            end else begin
                e.spc = 1; e.sif = 1; e.sid = 1;
                if (dmem_stall) e.sem = 1; else e.fem = 1;
                m_waited[k]++;
            end
        end
        if (e.spc && m_stalls[k] < SAT) m_stalls[k]++;
        if (rst) model_reset(k);
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        ctl_t e;
        for (int k = 0; k < 2; k++) begin
            if (rst) model_reset(k);
            chk("stall_cycles", k, o_sc[k], m_stalls[k]);
            chk("flush_count", k, o_fc[k], m_flush[k]);
            chk("md_error", k, o_err[k], m_err[k]);
            model_step(k, e);
            chk("stall_PC", k, o_spc[k], e.spc);
            chk("stall_IF_ID", k, o_sif[k], e.sif);
            chk("stall_ID_EX", k, o_sid[k], e.sid);
            chk("stall_EX_MEM", k, o_sem[k], e.sem);
            chk("flush_IF_ID", k, o_fif[k], e.fif);
            chk("flush_ID_EX", k, o_fid[k], e.fid);
            chk("flush_EX_MEM", k, o_fem[k], e.fem);
            chk("md_start", k, o_start[k], e.start);
            chk("md_abort", k, o_abort[k], e.abort);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        opcode_ID = OP_CAL_I; rs1_ID = '0; rs2_ID = '0; rd_EX = '0;
        mem_read_EX = 0; branch_taken_EX = 0; md_EX = 0; md_done = 0; dmem_stall = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        cyc();
        cyc();
        rst = 0;
    endtask

    initial begin
        logic [6:0] ops [10];
        int starts, holds, aborts, abort_at;
        ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                OP_STORE, OP_CAL_I, OP_CAL_R, 7'h00};
        rst = 1;
        idle();
        #1;
        chk("rst_stall_cycles", 0, o_sc[0], 0);
        chk("rst_md_error", 0, o_err[0], 0);
        chk("rst_stall_PC", 0, o_spc[0], 0);
        cyc();
        cyc();
        rst = 0;
        cyc();

        // Timeout on the 4-cycle instance: abort on the 4th wait cycle only
        md_EX = 1;
        #1 chk("to_md_start", 1, o_start[1], 1);
        cyc();
        md_EX = 0;
        aborts = 0; abort_at = -1;
        for (int i = 1; i <= 6; i++) begin
            #1;
            if (o_abort[1]) begin aborts++; abort_at = i; end
            cyc();
        end
        chk("to_abort_count", 1, aborts, 1);
        chk("to_abort_cycle", 1, abort_at, 4);
        chk("to_md_error", 1, o_err[1], 1);
        chk("to_no_error64", 0, o_err[0], 0);
        md_done = 1;
        cyc();
        md_done = 0;
        cyc();
        chk("to_error_sticky", 1, o_err[1], 1);
        do_reset();
        #1 chk("to_error_cleared", 1, o_err[1], 0);
        cyc();

        // Load-use: one stall cycle, then LUI in ID does not stall
        mem_read_EX = 1; rd_EX = 5; opcode_ID = OP_CAL_R; rs1_ID = 5; rs2_ID = 1;
        #1 chk("lu_stall_PC", 0, o_spc[0], 1);
        chk("lu_flush_ID_EX", 0, o_fid[0], 1);
        cyc();
        idle();
        chk("lu_stall_cycles", 0, o_sc[0], 1);
        mem_read_EX = 1; rd_EX = 5; opcode_ID = OP_LUI; rs1_ID = 5;
        #1 chk("lui_no_stall", 0, o_spc[0], 0);
        cyc();

        // Branch together with load-use: redirect wins
        mem_read_EX = 1; rd_EX = 5; opcode_ID = OP_CAL_R; rs1_ID = 5; branch_taken_EX = 1;
        #1 chk("br_flush_IF_ID", 0, o_fif[0], 1);
        chk("br_stall_PC", 0, o_spc[0], 0);
        cyc();
        idle();
        chk("br_flush_count", 0, o_fc[0], 1);

        // Mul/div with done five cycles after start
        md_EX = 1; starts = 0; holds = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            starts += int'(o_start[0]);
            if (o_spc[0] && o_sif[0] && o_sid[0] && o_fem[0]) holds++;
            cyc();
        end
        md_done = 1;
        #1 chk("md_done_release", 0, o_spc[0], 0);
        chk("md_no_restart", 0, o_start[0], 0);
        cyc();
        idle();
        chk("md_start_count", 0, starts, 1);
        chk("md_hold_count", 0, holds, 5);

        // Data-memory stall during the mul/div wait
        md_EX = 1;
        cyc();
        cyc();
        dmem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("mdw_stall_EX_MEM", 0, o_sem[0], 1);
            chk("mdw_flush_EX_MEM", 0, o_fem[0], 0);
            cyc();
        end
        dmem_stall = 0;
        cyc();
        md_done = 1;
        #1 chk("mdw_done", 0, o_spc[0], 0);
        cyc();
        idle();

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            opcode_ID       = ops[$urandom_range(0, 9)];
            rs1_ID          = AW'($urandom_range(0, 3));
            rs2_ID          = AW'($urandom_range(0, 3));
            rd_EX           = AW'($urandom_range(0, 3));
            mem_read_EX     = ($urandom_range(0, 1) == 1);
            branch_taken_EX = ($urandom_range(0, 99) < 15);
            md_EX           = ($urandom_range(0, 99) < 6);
            md_done         = ($urandom_range(0, 99) < 15);
            dmem_stall      = ($urandom_range(0, 99) < 10);
            cyc();
        end
        idle();
        md_done = 1;
        cyc();
        md_done = 0;

        // Asynchronous reset in the middle of a mul/div wait
        md_EX = 1;
        cyc();
        md_EX = 0;
        cyc();
        cyc();
        #2 rst = 1;
        #1 chk("arst_stall_PC", 0, o_spc[0], 0);
        chk("arst_stall_cycles", 0, o_sc[0], 0);
        chk("arst_flush_count", 0, o_fc[0], 0);
        chk("arst_md_error", 1, o_err[1], 0);
        @(posedge clk);
        #2 rst = 0;
        cyc();

        // Drive the stall counter into saturation
        dmem_stall = 1;
        repeat (SAT + 5) cyc();
        dmem_stall = 0;
        chk("sat_stall_cycles", 0, o_sc[0], 16'hFFFF);
        cyc();
        chk("sat_hold", 0, o_sc[0], 16'hFFFF);
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
